branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/mips_core_pkg.sv | 24 ++
 rtl/btb_sat_counter.sv | 20 ++
 rtl/branch_target_buffer.sv | 141 ++++++++++++++
 tb/tb_branch_target_buffer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared core types: branch outcome, BTB FSM state and BTB entry layout
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

    typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} BranchOutcome;

    typedef enum logic {INIT = 1'b0, READY = 1'b1} BtbState;

    localparam int BTB_TAG_W = `ADDR_WIDTH - 2;
    localparam int BTB_TGT_W = `ADDR_WIDTH;

    // Fields are sized for the widest configuration; narrower instances zero-extend.
    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_TGT_W-1:0] target;
        logic [1:0]           cnt;
        logic                 jump;
    } btb_entry_t;

endpackage

// File: rtl/btb_sat_counter.sv
// rtl/btb_sat_counter.sv - 2-bit saturating up/down counter next-state with hold
module btb_sat_counter (
    input  logic [1:0] cnt,
    input  logic       inc,
    input  logic       hold,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (!hold) begin
            if (inc && cnt != 2'b11) begin
                cnt_next = cnt + 2'd1;
            end else if (!inc && cnt != 2'b00) begin
                cnt_next = cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with INIT sweep; BTB_STATS_EN adds lookup/hit counters
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_target_buffer
    import mips_core_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int ADDR_W     = `ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_lookup_valid,
    input  logic [ADDR_W-1:0] i_lookup_pc,
    output logic              o_ready,
    output logic              o_hit,
    output logic              o_pred_taken,
    output logic [ADDR_W-1:0] o_pred_target,
    input  logic              i_update_valid,
    input  logic [ADDR_W-1:0] i_update_pc,
    input  logic [ADDR_W-1:0] i_update_target,
    input  BranchOutcome      i_update_outcome,
    input  logic              i_update_is_jump
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]       o_lookup_count,
    output logic [31:0]       o_hit_count
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LSB = INDEX_BITS + 2;

    BtbState               state_q, state_d;
    logic [INDEX_BITS-1:0] sweep_idx_q, sweep_idx_d;
    btb_entry_t            entries_q [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx, up_idx;
    logic [BTB_TAG_W-1:0]  lk_tag, up_tag;
    btb_entry_t            lk_entry, up_entry, upd_entry_d;
    logic                  upd_en, upd_hit, upd_alloc, upd_taken;
    logic [1:0]            cnt_next;
    logic                  unused_pc_lsbs;

    assign unused_pc_lsbs = ^{i_lookup_pc[1:0], i_update_pc[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= INIT;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = '0;
        if (i_flush) begin
            state_d = INIT;
        end else if (state_q == INIT) begin
            sweep_idx_d = sweep_idx_q + INDEX_BITS'(1);
            if (sweep_idx_q == '1) begin
                state_d = READY;
            end
        end
    end

    always_comb begin
        o_ready = (state_q == READY);
    end

    assign lk_idx   = i_lookup_pc[TAG_LSB-1:2];
    assign lk_tag   = BTB_TAG_W'(i_lookup_pc[ADDR_W-1:TAG_LSB]);
    assign lk_entry = entries_q[lk_idx];

    // Lookup reads the registered table, so a same-cycle update is never bypassed.
    assign o_hit         = o_ready & i_lookup_valid & lk_entry.valid & (lk_entry.tag == lk_tag);
    assign o_pred_taken  = o_hit & (lk_entry.jump | lk_entry.cnt[1]);
    assign o_pred_target = o_hit ? ADDR_W'(lk_entry.target) : '0;

    assign up_idx    = i_update_pc[TAG_LSB-1:2];
    assign up_tag    = BTB_TAG_W'(i_update_pc[ADDR_W-1:TAG_LSB]);
    assign up_entry  = entries_q[up_idx];
    assign upd_taken = (i_update_outcome == TAKEN);
    assign upd_en    = rst_n & o_ready & i_update_valid & ~i_flush;
    assign upd_hit   = up_entry.valid & (up_entry.tag == up_tag);
    assign upd_alloc = ~upd_hit & (upd_taken | i_update_is_jump);

    btb_sat_counter u_sat_counter (
        .cnt      (up_entry.cnt),
        .inc      (upd_taken),
        .hold     (~upd_hit),
        .cnt_next (cnt_next)
    );

    always_comb begin
        upd_entry_d = up_entry;
        if (upd_alloc) begin
            upd_entry_d.valid  = 1'b1;
            upd_entry_d.tag    = up_tag;
            upd_entry_d.target = BTB_TGT_W'(i_update_target);
            upd_entry_d.cnt    = i_update_is_jump ? 2'b11 : 2'b10;
            upd_entry_d.jump   = i_update_is_jump;
        end else begin
            upd_entry_d.cnt = i_update_is_jump ? 2'b11 : cnt_next;
            if (upd_taken || i_update_is_jump) begin
                upd_entry_d.target = BTB_TGT_W'(i_update_target);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && state_q == INIT) begin
            entries_q[sweep_idx_q].valid <= 1'b0;
        end else if (upd_en && (upd_hit || upd_alloc)) begin
            entries_q[up_idx] <= upd_entry_d;
        end
    end

`ifdef BTB_STATS_EN
    // Statistics survive a flush; only rst_n clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_lookup_count <= '0;
            o_hit_count    <= '0;
        end else if (o_ready) begin
            if (i_lookup_valid) begin
                o_lookup_count <= o_lookup_count + 32'd1;
            end
            if (o_hit) begin
                o_hit_count <= o_hit_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - directed self-checking bench for branch_target_buffer
`timescale 1ns/1ps
module tb_branch_target_buffer;
    import mips_core_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_flush;
    logic         i_lookup_valid;
    logic [31:0]  i_lookup_pc;
    logic         o_ready;
    logic         o_hit;
    logic         o_pred_taken;
    logic [31:0]  o_pred_target;
    logic         i_update_valid;
    logic [31:0]  i_update_pc;
    logic [31:0]  i_update_target;
    BranchOutcome i_update_outcome;
    logic         i_update_is_jump;
`ifdef BTB_STATS_EN
    logic [31:0]  o_lookup_count;
    logic [31:0]  o_hit_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    branch_target_buffer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_flush          (i_flush),
        .i_lookup_valid   (i_lookup_valid),
        .i_lookup_pc      (i_lookup_pc),
        .o_ready          (o_ready),
        .o_hit            (o_hit),
        .o_pred_taken     (o_pred_taken),
        .o_pred_target    (o_pred_target),
        .i_update_valid   (i_update_valid),
        .i_update_pc      (i_update_pc),
        .i_update_target  (i_update_target),
        .i_update_outcome (i_update_outcome),
        .i_update_is_jump (i_update_is_jump)
`ifdef BTB_STATS_EN
        ,
        .o_lookup_count   (o_lookup_count),
        .o_hit_count      (o_hit_count)
`endif
    );

    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt,
                             input BranchOutcome oc, input logic jmp);
        @(negedge clk);
        i_update_pc      = pc;
        i_update_target  = tgt;
        i_update_outcome = oc;
        i_update_is_jump = jmp;
        i_update_valid   = 1'b1;
        @(negedge clk);
        i_update_valid   = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        @(negedge clk);
        i_lookup_valid = 1'b1;
        i_lookup_pc    = pc;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        i_lookup_valid = 1'b1;
        i_lookup_pc = 32'h100;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready got %b want 0", o_ready);
        end
        vectors++;
        if (o_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hit got %b want 0", o_hit);
        end
        // Abort a sweep mid-way with rst_n; the count must restart from zero.
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midsweep_reset_ready got %b want 0", o_ready);
        end
        rst_n = 1'b1;
        for (int c = 0; c <= 32; c++) begin
            #1;
            vectors++;
            if (o_ready !== (c == 32)) begin
                miscompares++;
                $display("FAIL init_ready cycle=%0d got %b want %b", c, o_ready, (c == 32));
            end
            vectors++;
            if (o_hit !== 1'b0) begin
                miscompares++;
                $display("FAIL init_hit cycle=%0d got %b want 0", c, o_hit);
            end
            if (c < 32) @(negedge clk);
        end
        i_lookup_valid = 1'b0;
    endtask

    task automatic test_alloc_hit;
        do_update(32'h100, 32'h80, TAKEN, 1'b0);
        look(32'h100);
        vectors++;
        if (o_hit !== 1'b1 || o_pred_taken !== 1'b1 || o_pred_target !== 32'h80) begin
            miscompares++;
            $display("FAIL alloc_lookup got hit=%b taken=%b tgt=%h want 1 1 00000080",
                     o_hit, o_pred_taken, o_pred_target);
        end
        look(32'h180);
        vectors++;
        if (o_hit !== 1'b0 || o_pred_taken !== 1'b0 || o_pred_target !== 32'h0) begin
            miscompares++;
            $display("FAIL other_tag got hit=%b taken=%b tgt=%h want 0 0 00000000",
                     o_hit, o_pred_taken, o_pred_target);
        end
    endtask

    task automatic test_counter;
        logic exp_nt [3];
        logic exp_t  [3];
        exp_nt = '{1'b0, 1'b0, 1'b0};
        exp_t  = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_update(32'h100, 32'h80, NOT_TAKEN, 1'b0);
            look(32'h100);
            vectors++;
            if (o_hit !== 1'b1 || o_pred_taken !== exp_nt[i]) begin
                miscompares++;
                $display("FAIL nt_step%0d got hit=%b taken=%b want 1 %b", i, o_hit, o_pred_taken, exp_nt[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_update(32'h100, 32'h80, TAKEN, 1'b0);
            look(32'h100);
            vectors++;
            if (o_hit !== 1'b1 || o_pred_taken !== exp_t[i]) begin
                miscompares++;
                $display("FAIL t_step%0d got hit=%b taken=%b want 1 %b", i, o_hit, o_pred_taken, exp_t[i]);
            end
        end
        // Saturated at 11: one NOT_TAKEN leaves 10, still predicting taken.
        do_update(32'h100, 32'h80, NOT_TAKEN, 1'b0);
        look(32'h100);
        vectors++;
        if (o_pred_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_high got taken=%b want 1", o_pred_taken);
        end
        do_update(32'h100, 32'h80, TAKEN, 1'b0);
    endtask

    task automatic test_same_cycle;
        @(negedge clk);
        i_update_pc      = 32'h100;
        i_update_target  = 32'h90;
        i_update_outcome = TAKEN;
        i_update_is_jump = 1'b0;
        i_update_valid   = 1'b1;
        i_lookup_valid   = 1'b1;
        i_lookup_pc      = 32'h100;
        #1;
        vectors++;
        if (o_hit !== 1'b1 || o_pred_target !== 32'h80) begin
            miscompares++;
            $display("FAIL same_cycle got hit=%b tgt=%h want 1 00000080", o_hit, o_pred_target);
        end
        @(negedge clk);
        i_update_valid = 1'b0;
        #1;
        vectors++;
        if (o_hit !== 1'b1 || o_pred_target !== 32'h90) begin
            miscompares++;
            $display("FAIL next_cycle got hit=%b tgt=%h want 1 00000090", o_hit, o_pred_target);
        end
    endtask

    task automatic test_jump;
        do_update(32'h200, 32'h400, TAKEN, 1'b1);
        look(32'h200);
        vectors++;
        if (o_hit !== 1'b1 || o_pred_taken !== 1'b1 || o_pred_target !== 32'h400) begin
            miscompares++;
            $display("FAIL jump_alloc got hit=%b taken=%b tgt=%h want 1 1 00000400",
                     o_hit, o_pred_taken, o_pred_target);
        end
        look(32'h100);
        vectors++;
        if (o_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL overwritten got hit=%b want 0", o_hit);
        end
        // Counter drops to 01 but the jump bit keeps the prediction taken.
        do_update(32'h200, 32'h404, NOT_TAKEN, 1'b0);
        do_update(32'h200, 32'h404, NOT_TAKEN, 1'b0);
        look(32'h200);
        vectors++;
        if (o_hit !== 1'b1 || o_pred_taken !== 1'b1 || o_pred_target !== 32'h400) begin
            miscompares++;
            $display("FAIL jump_nt got hit=%b taken=%b tgt=%h want 1 1 00000400",
                     o_hit, o_pred_taken, o_pred_target);
        end
        do_update(32'h300, 32'h500, NOT_TAKEN, 1'b0);
        look(32'h300);
        vectors++;
        if (o_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL nt_miss_alloc got hit=%b want 0", o_hit);
        end
        look(32'h200);
        vectors++;
        if (o_hit !== 1'b1 || o_pred_target !== 32'h400) begin
            miscompares++;
            $display("FAIL nt_miss_kept got hit=%b tgt=%h want 1 00000400", o_hit, o_pred_target);
        end
    endtask

    task automatic test_flush;
        @(negedge clk);
        i_flush          = 1'b1;
        i_update_pc      = 32'h300;
        i_update_target  = 32'h600;
        i_update_outcome = TAKEN;
        i_update_is_jump = 1'b0;
        i_update_valid   = 1'b1;
        i_lookup_valid   = 1'b1;
        i_lookup_pc      = 32'h200;
        #1;
        vectors++;
        if (o_hit !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_cycle_hit got %b want 1", o_hit);
        end
        @(negedge clk);
        i_flush = 1'b0;
        i_update_valid = 1'b0;
        for (int c = 0; c <= 32; c++) begin
            #1;
            vectors++;
            if (o_ready !== (c == 32) || o_hit !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_sweep cycle=%0d got ready=%b hit=%b want %b 0", c, o_ready, o_hit, (c == 32));
            end
            if (c < 32) @(negedge clk);
        end
        look(32'h300);
        vectors++;
        if (o_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_dropped_update got hit=%b want 0", o_hit);
        end
        // Flush during INIT restarts the sweep from index 0.
        @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        repeat (10) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        for (int c = 0; c <= 32; c++) begin
            #1;
            vectors++;
            if (o_ready !== (c == 32)) begin
                miscompares++;
                $display("FAIL init_flush_restart cycle=%0d got %b want %b", c, o_ready, (c == 32));
            end
            if (c < 32) @(negedge clk);
        end
        i_lookup_valid = 1'b0;
    endtask

`ifdef BTB_STATS_EN
    task automatic test_stats;
        logic [31:0] pcs [10];
        pcs = '{32'h100, 32'h104, 32'h108, 32'h180, 32'h100,
                32'h10C, 32'h110, 32'h104, 32'h200, 32'h300};
        i_lookup_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (32) @(negedge clk);
        #1;
        vectors++;
        if (o_ready !== 1'b1 || o_lookup_count !== 32'd0 || o_hit_count !== 32'd0) begin
            miscompares++;
            $display("FAIL stats_reset got ready=%b lk=%0d hit=%0d want 1 0 0", o_ready, o_lookup_count, o_hit_count);
        end
        do_update(32'h100, 32'h80, TAKEN, 1'b0);
        do_update(32'h104, 32'h84, TAKEN, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            i_lookup_valid = 1'b1;
            i_lookup_pc = pcs[i];
        end
        @(negedge clk);
        i_lookup_valid = 1'b0;
        #1;
        vectors++;
        if (o_lookup_count !== 32'd10 || o_hit_count !== 32'd4) begin
            miscompares++;
            $display("FAIL stats_count got lk=%0d hit=%0d want 10 4", o_lookup_count, o_hit_count);
        end
        @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        repeat (33) @(negedge clk);
        #1;
        vectors++;
        if (o_lookup_count !== 32'd10 || o_hit_count !== 32'd4) begin
            miscompares++;
            $display("FAIL stats_flush got lk=%0d hit=%0d want 10 4", o_lookup_count, o_hit_count);
        end
    endtask
`endif

    initial begin
        rst_n            = 1'b0;
        i_flush          = 1'b0;
        i_lookup_valid   = 1'b0;
        i_lookup_pc      = '0;
        i_update_valid   = 1'b0;
        i_update_pc      = '0;
        i_update_target  = '0;
        i_update_outcome = NOT_TAKEN;
        i_update_is_jump = 1'b0;
        test_reset();
        test_alloc_hit();
        test_counter();
        test_same_cycle();
        test_jump();
        test_flush();
`ifdef BTB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
